// File: rtl/sc_chain_reg.sv
// Scan-chain register: capture PIN, shift WIDTH bits SIN->SO, update shadow driving PO (optional SC_PARITY_EN adds SPAR/PERR).
// START to DONE is WIDTH+1 edges; HOLD stalls shifting, and CAP/START are dropped (not queued) while BUSY.
module sc_chain_reg #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter bit               MSB_FIRST = 1'b0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             SIN,
   output logic             SO,
   input  logic [WIDTH-1:0] PIN,
   output logic [WIDTH-1:0] PO,
   input  logic             SEL,
   input  logic             BYP_N,
   input  logic             CAP,
   input  logic             START,
   input  logic             HOLD,
   output logic             BUSY,
   output logic             DONE
`ifdef SC_PARITY_EN
   ,
   input  logic             SPAR,
   output logic             PERR
`endif
);

   localparam int             CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0]  ONE  = CW'(1);

   typedef enum logic [1:0] {IDLE, SHIFT, UPDT} state_t;

   state_t           state;
   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] shift_nxt;
   logic [WIDTH-1:0] shadow;
   logic [CW-1:0]    count;

   // Data moves toward the SO end; SIN fills the vacated end.
   always_comb begin
      shift_nxt = shift_reg;
      if (MSB_FIRST)
         shift_nxt = {shift_reg[WIDTH-2:0], SIN};
      else
         shift_nxt = {SIN, shift_reg[WIDTH-1:1]};
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         shift_reg <= '0;
         shadow    <= RESET_VAL;
         count     <= '0;
         DONE      <= 1'b0;
`ifdef SC_PARITY_EN
         PERR      <= 1'b0;
`endif
      end else begin
         DONE <= 1'b0;
         case (state)
            IDLE: begin
               if (CAP)
                  shift_reg <= PIN;
               if (START) begin
                  count <= '0;
                  state <= SHIFT;
`ifdef SC_PARITY_EN
                  PERR  <= 1'b0;
`endif
               end
            end
            SHIFT: begin
               if (!HOLD) begin
                  shift_reg <= shift_nxt;
                  if (count == LAST) begin
                     count <= '0;
                     state <= UPDT;
                  end else begin
                     count <= count + ONE;
                  end
               end
            end
            UPDT: begin
`ifdef SC_PARITY_EN
               if ((^shift_reg) != SPAR) begin
                  PERR <= 1'b1;
               end else begin
                  PERR   <= 1'b0;
                  shadow <= shift_reg;
               end
`else
               shadow <= shift_reg;
`endif
               DONE  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign SO   = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];
   assign PO   = (SEL & ~BYP_N) ? PIN : shadow;
   assign BUSY = (state != IDLE);

endmodule
